dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
- Controller that sequences one DSP48A1 slice as a dot-product engine: sum over k of (a_k * b_k), optionally negated.
- Accepts a job (start + length), streams operand pairs in over a valid/ready handshake, and drives the slice's A/B, OPMODE, CE and RSTP pins.
- Tracks pipeline validity, then returns the 48-bit P result over a valid/ready handshake.
- Integration: the slice is instantiated with all pipeline registers enabled (A0/A1/B0/B1/M/P/OPMODE = 1), B_INPUT="DIRECT", CARRYINSEL="OPMODE5", RSTTYPE="SYNC".

Parameters:
- LEN_W, 8, width of the job length (max products per job = 2^LEN_W-1).
- MUL_LAT, 3, cycles from operand on the slice's A/B pins to the product on its M output.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- start  in  1  job start pulse; sampled in IDLE only
- len  in  LEN_W  number of operand pairs; sampled with start
- negate  in  1  1 = result is -(dot product); sampled with start
- busy  out  1  high whenever state != IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer accepts a pair this cycle
- in_a  in  18  signed operand a
- in_b  in  18  signed operand b
- dsp_A  out  18  to slice A; in_a on accept, else 0
- dsp_B  out  18  to slice B; in_b on accept, else 0
- dsp_CE  out  1  to slice CEA/CEB/CEM/CEOPMODE; equals ~RST
- dsp_OPMODE  out  8  to slice OPMODE
- dsp_CEP  out  1  to slice CEP
- dsp_RSTP  out  1  to slice RSTP/RSTM/RSTA/RSTB/RSTOPMODE; equals RST
- dsp_P  in  48  from slice P
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_data  out  48  signed result

Behaviour:
- Reset: state=IDLE; busy=0, in_ready=0, res_valid=0, res_data=0, dsp_CEP=0, dsp_OPMODE=0, tag pipeline cleared, dsp_RSTP=1.
- Reset mid-job aborts the job. No partial result is emitted.
- FSM IDLE -> LOAD -> DRAIN -> DONE -> IDLE.
  - IDLE: on start & len!=0, latch len into remaining, latch negate, go to LOAD. On start & len==0, res_data<=0 and go to DONE (res_valid high the next cycle).
  - LOAD: in_ready=1; accept = in_valid & in_ready.
    - Each accept decrements remaining and pushes a tag (valid=1, first = this is the job's first pair) into a MUL_LAT-deep shift register that advances every cycle. Non-accept cycles push valid=0.
    - The accept of the last pair (remaining==1) moves to DRAIN.
    - in_valid gaps insert bubbles; there is no stall of the slice pipeline.
  - DRAIN: in_ready=0. Wait until the last tag has left stage MUL_LAT and P has updated. The cycle after the last dsp_CEP pulse, capture res_data<=dsp_P and go to DONE.
  - DONE: res_valid=1 and res_data held stable until res_ready=1; then IDLE. res_valid is cleared in that same handshake cycle.
- start is ignored outside IDLE. in_valid is ignored outside LOAD.
- OPMODE alignment:
  - dsp_OPMODE is driven from the tag at stage MUL_LAT-1, because the slice registers OPMODE once.
  - Tag valid & first: OPMODE = {negate,0,0,0,2'b00,2'b01} (Z=0, X=M).
  - Tag valid & !first: {negate,0,0,0,2'b10,2'b01} (Z=P, X=M).
  - No valid tag: 8'h00.
  - Bits 6/5/4 are always 0: no pre-adder, carry-in 0, B direct.
- Negation: with negate=1, the first product gives P = 0 - M. Each later product gives P = P - M. The final result is therefore -sum.
- dsp_CEP = tag valid at stage MUL_LAT, so P updates exactly once per accepted pair.
- Latency: for an accept at cycle t, P reflects the pair from cycle t+MUL_LAT+1. res_valid rises at t_last+MUL_LAT+2 (cycle 5 for len=1 accepted at cycle 0).
- Arithmetic: 18x18 signed gives a 36-bit product, sign-extended by the slice. For LEN_W<=12 the 48-bit accumulation cannot overflow, so no saturation is applied.

Test Plan:
- len=3, negate=0, pairs (2,3),(4,5),(-1,7) back-to-back from cycle 1 -> res_data=19, res_valid first high at cycle 3+3+2=8; OPMODE sequence 0x01,0x09,0x09.
- Same job with negate=1 -> res_data=-19 (0xFFFF_FFFF_FFED); OPMODE 0x81,0x89,0x89.
- len=4, pairs (1,1),(2,2),(3,3),(4,4) with in_valid low for 2 cycles between each pair -> res_data=30; dsp_CEP pulses exactly 4 times; dsp_A=0 during gaps.
- start with len=0 -> DONE next cycle with res_data=0; dsp_CEP never asserts; start pulses during LOAD/DRAIN/DONE are ignored.
- res_ready held low 10 cycles in DONE -> res_valid and res_data stable; in_ready=0; the next job starts only after the handshake.
- RST asserted after the 2nd of 5 accepts -> next cycle: IDLE, busy=0, res_valid=0, no dsp_CEP. A following job (-131072,-131072) x1 -> res_data=2^34.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
//   Sequences one DSP48A1 slice as a dot-product engine: P = +/- sum(a_k * b_k).
//   The slice sits outside this module with every pipeline register enabled
//   (A0/A1/B0/B1/M/P/OPMODE), B input direct, carry-in select from OPMODE[5],
//   and synchronous resets.
//
// Ports
//   CLK, RST           clock, synchronous active-high reset
//   start/len/negate   job request, sampled in IDLE only
//   busy               high whenever a job is in progress
//   in_valid/in_ready  operand-pair handshake, in_a/in_b signed 18-bit
//   dsp_A/dsp_B        operands to the slice (zero on non-accept cycles)
//   dsp_CE/dsp_RSTP    global clock enable / reset to the slice
//   dsp_OPMODE         slice OPMODE, aligned to the product reaching M
//   dsp_CEP            P register enable, one pulse per accepted pair
//   dsp_P              slice P output
//   res_valid/res_ready/res_data  48-bit signed result handshake
module dsp_mac_sequencer #(
    parameter int LEN_W   = 8,
    parameter int MUL_LAT = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic               negate,
    output logic               busy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [17:0] in_a,
    input  logic signed [17:0] in_b,
    output logic [17:0]        dsp_A,
    output logic [17:0]        dsp_B,
    output logic               dsp_CE,
    output logic [7:0]         dsp_OPMODE,
    output logic               dsp_CEP,
    output logic               dsp_RSTP,
    input  logic [47:0]        dsp_P,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [47:0]        res_data
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] remaining;
    logic             neg_q;
    logic             first_q;      // next accepted pair is the job's first
    logic             accept;
    logic             pipe_empty;
    logic [1:0]       opm_z;

    // Tag pipeline: stage k holds the pair accepted k cycles ago.
    logic [MUL_LAT:1] vld_pipe;
    logic [MUL_LAT:1] first_pipe;

    assign accept     = in_valid & in_ready;
    assign pipe_empty = ~|vld_pipe;

    assign dsp_A    = accept ? in_a : '0;
    assign dsp_B    = accept ? in_b : '0;
    assign dsp_CE   = ~RST;
    assign dsp_RSTP = RST;

    // OPMODE is registered once inside the slice, so it is issued one stage
    // early to land together with the product on M. First product starts
    // from Z=0, later ones accumulate onto P; bit 7 selects subtraction.
    assign opm_z      = first_pipe[MUL_LAT-1] ? 2'b00 : 2'b10;
    assign dsp_OPMODE = vld_pipe[MUL_LAT-1] ? {neg_q, 3'b000, opm_z, 2'b01} : 8'h00;
    assign dsp_CEP    = vld_pipe[MUL_LAT];

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nxt = (len != '0) ? LOAD : DONE;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && remaining == LEN_W'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                // Empty pipe means the last CEP pulse was last cycle, so P
                // now holds the final sum.
                if (pipe_empty) state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            remaining  <= '0;
            neg_q      <= 1'b0;
            first_q    <= 1'b0;
            vld_pipe   <= '0;
            first_pipe <= '0;
            res_data   <= '0;
        end else begin
            state      <= state_nxt;
            vld_pipe   <= {vld_pipe[MUL_LAT-1:1], accept};
            first_pipe <= {first_pipe[MUL_LAT-1:1], accept & first_q};
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= len;
                        neg_q     <= negate;
                        first_q   <= 1'b1;
                        if (len == '0) res_data <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        remaining <= remaining - 1'b1;
                        first_q   <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (pipe_empty) res_data <= dsp_P;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural DSP48A1 slice model closes the
// loop on dsp_P; expected dot products are queued when a job is driven and
// popped when the result handshake appears.
module tb_dsp_mac_sequencer;

    localparam int LEN_W   = 8;
    localparam int MUL_LAT = 3;

    logic               CLK = 1'b0;
    logic               RST;
    logic               start;
    logic [LEN_W-1:0]   len;
    logic               negate;
    logic               busy;
    logic               in_valid;
    logic               in_ready;
    logic signed [17:0] in_a, in_b;
    logic [17:0]        dsp_A, dsp_B;
    logic               dsp_CE;
    logic [7:0]         dsp_OPMODE;
    logic               dsp_CEP;
    logic               dsp_RSTP;
    logic [47:0]        dsp_P;
    logic               res_valid;
    logic               res_ready;
    logic [47:0]        res_data;

    dsp_mac_sequencer #(.LEN_W(LEN_W), .MUL_LAT(MUL_LAT)) dut (
        .CLK(CLK), .RST(RST), .start(start), .len(len), .negate(negate),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .dsp_A(dsp_A), .dsp_B(dsp_B),
        .dsp_CE(dsp_CE), .dsp_OPMODE(dsp_OPMODE), .dsp_CEP(dsp_CEP),
        .dsp_RSTP(dsp_RSTP), .dsp_P(dsp_P), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---- DSP48A1 slice model (A0/A1/B0/B1/M/OPMODE/P registered) ----
    logic signed [17:0] sa0, sa1, sb0, sb1;
    logic signed [35:0] prod;
    logic [47:0]        sm, sp, xmux, zmux;
    logic [7:0]         sopm;

    assign prod  = 36'(sa1) * 36'(sb1);
    assign xmux  = (sopm[1:0] == 2'b01) ? sm : 48'd0;
    assign zmux  = (sopm[3:2] == 2'b10) ? sp : 48'd0;
    assign dsp_P = sp;

    always @(posedge CLK) begin
        if (dsp_RSTP) begin
            sa0 <= '0; sa1 <= '0; sb0 <= '0; sb1 <= '0;
            sm <= '0; sopm <= '0; sp <= '0;
        end else begin
            if (dsp_CE) begin
                sa0  <= dsp_A; sa1 <= sa0;
                sb0  <= dsp_B; sb1 <= sb0;
                sm   <= {{12{prod[35]}}, prod};
                sopm <= dsp_OPMODE;
            end
            if (dsp_CEP) sp <= sopm[7] ? (zmux - xmux) : (zmux + xmux);
        end
    end

    // ---- passive monitors ----
    int         cep_cnt = 0;
    int         gap_err = 0;
    logic [7:0] opm_log[$];

    always @(negedge CLK) begin
        if (dsp_CEP) cep_cnt <= cep_cnt + 1;
        if (!(in_valid && in_ready) && (dsp_A != 18'd0 || dsp_B != 18'd0))
            gap_err <= gap_err + 1;
        if (dsp_OPMODE != 8'h00) opm_log.push_back(dsp_OPMODE);
    end

    // ---- scoreboard / checking ----
    int          vectors = 0;
    int          miscompares = 0;
    logic [47:0] exp_q[$];
    int          va[8];
    int          vb[8];
    int          job_c0;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive a job: queue its expected result, pulse start, then feed n pairs
    // with 'gap' idle cycles after each. With poke set, stray start pulses
    // (len=0) are thrown in during LOAD and DRAIN.
    task automatic run_job(input int n, input bit neg, input int gap, input bit poke);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(va[i]) * longint'(vb[i]);
        if (neg) s = -s;
        exp_q.push_back(s[47:0]);
        start  = 1'b1;
        len    = LEN_W'(n);
        negate = neg;
        job_c0 = cyc;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_a     = 18'(va[i]);
            in_b     = 18'(vb[i]);
            tick();
            in_valid = 1'b0;
            in_a     = '0;
            in_b     = '0;
            for (int g = 0; g < gap; g++) begin
                if (poke && i == 0 && g == 0) begin
                    start = 1'b1;
                    len   = '0;
                end
                tick();
                start = 1'b0;
            end
        end
        if (poke) begin
            start = 1'b1;
            len   = '0;
            tick();
            start = 1'b0;
        end
    endtask

    // Wait (bounded) for res_valid; optionally check its latency from start.
    task automatic wait_res(input string tag, input int lat);
        int t = 0;
        while (!res_valid && t < 100) begin
            tick();
            t++;
        end
        check({tag, "_valid"}, 48'(res_valid), 48'd1);
        if (lat >= 0) check({tag, "_lat"}, 48'(cyc - job_c0), 48'(lat));
    endtask

    task automatic pop_check(input string tag);
        logic [47:0] e;
        if (exp_q.size() == 0) e = 48'hDEAD_DEAD_DEAD;
        else e = exp_q.pop_front();
        check({tag, "_data"}, res_data, e);
    endtask

    task automatic check_opm(input string tag, input logic [7:0] e0, input logic [7:0] e1);
        check({tag, "_opm_n"}, 48'(opm_log.size()), 48'd3);
        for (int i = 0; i < 3; i++)
            check({tag, "_opm"}, (i < opm_log.size()) ? 48'(opm_log[i]) : 48'hFFFF,
                  48'((i == 0) ? e0 : e1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cep0;
        logic [47:0] held;

        RST = 1'b1; start = 1'b0; len = '0; negate = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b1;
        repeat (2) tick();

        // reset state
        check("rst_busy",  48'(busy), 48'd0);
        check("rst_rdy",   48'(in_ready), 48'd0);
        check("rst_rv",    48'(res_valid), 48'd0);
        check("rst_data",  res_data, 48'd0);
        check("rst_cep",   48'(dsp_CEP), 48'd0);
        check("rst_opm",   48'(dsp_OPMODE), 48'd0);
        check("rst_rstp",  48'(dsp_RSTP), 48'd1);
        check("rst_ce",    48'(dsp_CE), 48'd0);
        RST = 1'b0;
        tick();
        check("ce_on",     48'(dsp_CE), 48'd1);

        // len=3 back-to-back, positive
        va[0] = 2; vb[0] = 3; va[1] = 4; vb[1] = 5; va[2] = -1; vb[2] = 7;
        opm_log.delete();
        run_job(3, 1'b0, 0, 1'b0);
        wait_res("pos3", 8);
        pop_check("pos3");
        check_opm("pos3", 8'h01, 8'h09);
        tick();

        // same job negated
        opm_log.delete();
        run_job(3, 1'b1, 0, 1'b0);
        wait_res("neg3", 8);
        pop_check("neg3");
        check("neg3_lit", res_data, 48'hFFFF_FFFF_FFED);
        check_opm("neg3", 8'h81, 8'h89);
        tick();

        // len=4 with 2-cycle gaps and stray starts during LOAD/DRAIN
        va[0] = 1; vb[0] = 1; va[1] = 2; vb[1] = 2; va[2] = 3; vb[2] = 3; va[3] = 4; vb[3] = 4;
        cep0 = cep_cnt;
        run_job(4, 1'b0, 2, 1'b1);
        wait_res("gap4", -1);
        pop_check("gap4");
        check("gap4_cep", 48'(cep_cnt - cep0), 48'd4);
        check("gap4_zero", 48'(gap_err), 48'd0);
        tick();
        check("gap4_idle", 48'(busy), 48'd0);
        check("gap4_rv",   48'(res_valid), 48'd0);

        // len=0
        cep0 = cep_cnt;
        exp_q.push_back(48'd0);
        start = 1'b1; len = '0; job_c0 = cyc;
        tick();
        start = 1'b0;
        wait_res("len0", 1);
        pop_check("len0");
        tick();
        check("len0_cep", 48'(cep_cnt - cep0), 48'd0);

        // result back-pressure: hold res_ready low for 10 cycles in DONE
        res_ready = 1'b0;
        va[0] = 3; vb[0] = -4; va[1] = 5; vb[1] = 6;
        run_job(2, 1'b0, 0, 1'b0);
        wait_res("hold", -1);
        held = res_data;
        pop_check("hold");
        start = 1'b1; len = 8'd1; in_valid = 1'b1; in_a = 18'd9; in_b = 18'd9;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_rv",   48'(res_valid), 48'd1);
            check("hold_data", res_data, held);
            check("hold_rdy",  48'(in_ready), 48'd0);
        end
        start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        res_ready = 1'b1;
        tick();
        check("hold_rel_rv",   48'(res_valid), 48'd0);
        check("hold_rel_busy", 48'(busy), 48'd0);
        check("hold_zero",     48'(gap_err), 48'd0);

        // reset after 2 of 5 accepts
        start = 1'b1; len = 8'd5; negate = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_a = 18'd7; in_b = 18'd7;
            tick();
        end
        in_valid = 1'b0; in_a = '0; in_b = '0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        cep0 = cep_cnt;
        check("abort_busy", 48'(busy), 48'd0);
        check("abort_rv",   48'(res_valid), 48'd0);
        check("abort_rdy",  48'(in_ready), 48'd0);
        check("abort_cep",  48'(dsp_CEP), 48'd0);
        repeat (6) tick();
        check("abort_cep_n", 48'(cep_cnt - cep0), 48'd0);
        check("abort_rv2",   48'(res_valid), 48'd0);

        // most-negative operands after the abort
        va[0] = -131072; vb[0] = -131072;
        run_job(1, 1'b0, 0, 1'b0);
        wait_res("maxneg", 6);
        pop_check("maxneg");
        check("maxneg_lit", res_data, 48'h4_0000_0000);
        tick();
        check("end_q", 48'(exp_q.size()), 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
